// File: rtl/johnson_seq_ctrl.sv
// Step controller for a WIDTH-stage Johnson counter used as a 2*WIDTH-phase sequencer.
// Define JOHNSON_SELF_CORRECT_EN to enable illegal-state recovery and the sticky err flag.
module johnson_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       dir,
  input  logic [STEP_W-1:0]          steps,
  input  logic                       abort,
  input  logic                       load,
  input  logic [WIDTH-1:0]           load_val,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           q,
  output logic [2*WIDTH-1:0]         phase,
  output logic [$clog2(2*WIDTH)-1:0] phase_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int IDX_W   = $clog2(2*WIDTH);
  localparam int SEQ_LEN = 2*WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  q_n, q_fwd, q_rev;
  logic [STEP_W-1:0] remaining, remaining_n;
  logic              dir_r, dir_n, busy_n, done_n;
  logic              err_set;
  int                pop_cnt, idx_val;

  assign q_fwd = {q[WIDTH-2:0], ~q[WIDTH-1]};
  assign q_rev = {~q[0], q[WIDTH-1:1]};

  // Ones count gives the distance from 0000 on the rising half, or back from the end on the falling half
  always_comb begin
    pop_cnt = 0;
    for (int i = 0; i < WIDTH; i++) pop_cnt = pop_cnt + int'(q[i]);
    idx_val   = q[0] ? pop_cnt : (SEQ_LEN - pop_cnt) % SEQ_LEN;
    phase_idx = IDX_W'(idx_val);
    phase     = {{(SEQ_LEN-1){1'b0}}, 1'b1} << phase_idx;
  end

`ifdef JOHNSON_SELF_CORRECT_EN
  logic [WIDTH-1:0] ones_low;
  logic             q_legal;

  always_comb begin
    q_legal  = 1'b0;
    ones_low = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (q == ones_low || q == ~ones_low) q_legal = 1'b1;
      ones_low = {ones_low[WIDTH-2:0], 1'b1};
    end
  end

  assign err_set = ~q_legal;
`else
  logic unused_err_clr;

  assign err_set        = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  always_comb begin
    state_n     = state;
    q_n         = q;
    remaining_n = remaining;
    dir_n       = dir_r;
    busy_n      = busy;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          q_n = load_val;
        end else if (start) begin
          if (steps != '0) begin
            dir_n       = dir;
            remaining_n = steps;
            state_n     = RUN;
            busy_n      = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n     = IDLE;
          busy_n      = 1'b0;
          done_n      = 1'b1;
          remaining_n = '0;
        end else begin
          q_n         = dir_r ? q_rev : q_fwd;
          remaining_n = remaining - STEP_W'(1);
          if (remaining == STEP_W'(1)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Recovery from an illegal pattern overrides everything else this cycle
    if (err_set) begin
      q_n         = '0;
      state_n     = IDLE;
      busy_n      = 1'b0;
      dir_n       = dir_r;
      done_n      = (state == RUN);
      remaining_n = (state == RUN) ? '0 : remaining;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      remaining <= '0;
      dir_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      remaining <= remaining_n;
      dir_r     <= dir_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

`ifdef JOHNSON_SELF_CORRECT_EN
  // Setting wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl (WIDTH=4, STEP_W=8); honours JOHNSON_SELF_CORRECT_EN.
module tb_johnson_seq_ctrl;
  logic       clk, rst_n, start, dir, abort, load, err_clr;
  logic [7:0] steps;
  logic [3:0] load_val, q;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       busy, done, err;

  typedef struct packed {
    logic       start;
    logic       dir;
    logic [7:0] steps;
    logic       abort;
    logic       load;
    logic [3:0] lv;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  johnson_seq_ctrl #(.WIDTH(4), .STEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .steps(steps),
    .abort(abort), .load(load), .load_val(load_val), .err_clr(err_clr),
    .q(q), .phase(phase), .phase_idx(phase_idx), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] fwd(input logic [3:0] m);
    return {m[2:0], ~m[3]};
  endfunction

  function automatic logic [3:0] rev(input logic [3:0] m);
    return {~m[0], m[3:1]};
  endfunction

  function automatic logic [2:0] exp_idx(input logic [3:0] v);
    int p;
    p = $countones(v);
    return v[0] ? 3'(p) : 3'((8 - p) % 8);
  endfunction

  function automatic stim_t mk(input logic s, input logic d, input logic [7:0] n,
                               input logic a, input logic l, input logic [3:0] v, input logic c);
    return {s, d, n, a, l, v, c};
  endfunction

  function automatic exp_t mkexp(input logic [3:0] m, input logic b, input logic d, input logic e);
    return {m, b, d, e};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; steps = '0; abort = 1'b0;
    load = 1'b0; load_val = '0; err_clr = 1'b0;
    #2;
    checks++;
    if ({q, phase, phase_idx, busy, done, err} !== {4'b0000, 8'b00000001, 3'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset: got q=%b phase=%b idx=%0d busy=%b done=%b err=%b, expected 0000/00000001/0/0/0/0",
               q, phase, phase_idx, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    exp_t       e;
    logic [3:0] m = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      start = (c == 0); dir = 1'b0; steps = 8'd8;
      if (c >= 1 && c <= 8) m = fwd(m);
      sb.push_back(mkexp(m, (c < 8), (c == 8), 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({q, busy, done, err} !== {e.q, e.busy, e.done, e.err}) begin
        errors++;
        $display("[TB] FAIL fwd[%0d] state: got q=%b busy=%b done=%b err=%b, expected q=%b busy=%b done=%b err=%b",
                 c, q, busy, done, err, e.q, e.busy, e.done, e.err);
      end
      checks++;
      if (phase_idx !== exp_idx(e.q) || phase !== (8'd1 << exp_idx(e.q))) begin
        errors++;
        $display("[TB] FAIL fwd[%0d] decode: got idx=%0d phase=%b, expected idx=%0d phase=%b",
                 c, phase_idx, phase, exp_idx(e.q), 8'd1 << exp_idx(e.q));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reverse();
    exp_t       e;
    logic [3:0] m = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      // A second start (with a load) while busy must be ignored
      start = (c == 0 || c == 2); dir = (c == 0); steps = (c == 0) ? 8'd3 : 8'd8;
      load = (c == 2); load_val = 4'b0111;
      if (c >= 1 && c <= 3) m = rev(m);
      sb.push_back(mkexp(m, (c < 3), (c == 3), 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({q, busy, done, err} !== {e.q, e.busy, e.done, e.err}) begin
        errors++;
        $display("[TB] FAIL rev[%0d] state: got q=%b busy=%b done=%b err=%b, expected q=%b busy=%b done=%b err=%b",
                 c, q, busy, done, err, e.q, e.busy, e.done, e.err);
      end
      checks++;
      if (phase_idx !== exp_idx(e.q) || phase !== (8'd1 << exp_idx(e.q))) begin
        errors++;
        $display("[TB] FAIL rev[%0d] decode: got idx=%0d phase=%b, expected idx=%0d phase=%b",
                 c, phase_idx, phase, exp_idx(e.q), 8'd1 << exp_idx(e.q));
      end
    end
    start = 1'b0; load = 1'b0; dir = 1'b0;
  endtask

  task automatic test_zero_steps();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st[0] = mk(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[0] = mkexp(4'b1110, 1'b0, 1'b1, 1'b0);
    st[1] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[1] = mkexp(4'b1110, 1'b0, 1'b0, 1'b0);
    st[2] = mk(1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 4'b0111, 1'b0); ex[2] = mkexp(4'b0111, 1'b0, 1'b0, 1'b0);
    st[3] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[3] = mkexp(4'b0111, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      {start, dir, steps, abort, load, load_val, err_clr} = st[c];
      sb.push_back(ex[c]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({q, busy, done, err} !== {e.q, e.busy, e.done, e.err}) begin
        errors++;
        $display("[TB] FAIL zero[%0d] state: got q=%b busy=%b done=%b err=%b, expected q=%b busy=%b done=%b err=%b",
                 c, q, busy, done, err, e.q, e.busy, e.done, e.err);
      end
    end
  endtask

  task automatic test_abort();
    stim_t st[14];
    exp_t  ex[14];
    exp_t  e;
    st[0]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0000, 1'b0); ex[0]  = mkexp(4'b0000, 1'b0, 1'b0, 1'b0);
    st[1]  = mk(1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 4'b0000, 1'b0); ex[1]  = mkexp(4'b0000, 1'b1, 1'b0, 1'b0);
    st[2]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[2]  = mkexp(4'b0001, 1'b1, 1'b0, 1'b0);
    st[3]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[3]  = mkexp(4'b0011, 1'b1, 1'b0, 1'b0);
    st[4]  = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b0000, 1'b0); ex[4]  = mkexp(4'b0011, 1'b0, 1'b1, 1'b0);
    st[5]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[5]  = mkexp(4'b0011, 1'b0, 1'b0, 1'b0);
    st[6]  = mk(1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 4'b0000, 1'b0); ex[6]  = mkexp(4'b0011, 1'b1, 1'b0, 1'b0);
    st[7]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[7]  = mkexp(4'b0111, 1'b1, 1'b0, 1'b0);
    st[8]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[8]  = mkexp(4'b1111, 1'b0, 1'b1, 1'b0);
    st[9]  = mk(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 4'b0000, 1'b0); ex[9]  = mkexp(4'b1111, 1'b1, 1'b0, 1'b0);
    st[10] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[10] = mkexp(4'b0111, 1'b1, 1'b0, 1'b0);
    st[11] = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b0000, 1'b0); ex[11] = mkexp(4'b0111, 1'b0, 1'b1, 1'b0);
    st[12] = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'b0000, 1'b0); ex[12] = mkexp(4'b0111, 1'b0, 1'b0, 1'b0);
    st[13] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0); ex[13] = mkexp(4'b0111, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 14; c++) begin
      {start, dir, steps, abort, load, load_val, err_clr} = st[c];
      sb.push_back(ex[c]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({q, busy, done, err} !== {e.q, e.busy, e.done, e.err}) begin
        errors++;
        $display("[TB] FAIL abort[%0d] state: got q=%b busy=%b done=%b err=%b, expected q=%b busy=%b done=%b err=%b",
                 c, q, busy, done, err, e.q, e.busy, e.done, e.err);
      end
    end
  endtask

  task automatic test_self_correct();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    st[0] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0101, 1'b0);
    st[1] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
    st[2] = mk(1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 4'b0000, 1'b1);
    st[3] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
    st[4] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
`ifdef JOHNSON_SELF_CORRECT_EN
    ex[0] = mkexp(4'b0101, 1'b0, 1'b0, 1'b0);
    ex[1] = mkexp(4'b0000, 1'b0, 1'b0, 1'b1);
    ex[2] = mkexp(4'b0000, 1'b1, 1'b0, 1'b0);
    ex[3] = mkexp(4'b0001, 1'b0, 1'b1, 1'b0);
    ex[4] = mkexp(4'b0001, 1'b0, 1'b0, 1'b0);
`else
    ex[0] = mkexp(4'b0101, 1'b0, 1'b0, 1'b0);
    ex[1] = mkexp(4'b0101, 1'b0, 1'b0, 1'b0);
    ex[2] = mkexp(4'b0101, 1'b1, 1'b0, 1'b0);
    ex[3] = mkexp(4'b1011, 1'b0, 1'b1, 1'b0);
    ex[4] = mkexp(4'b1011, 1'b0, 1'b0, 1'b0);
`endif
    for (int c = 0; c < 5; c++) begin
      {start, dir, steps, abort, load, load_val, err_clr} = st[c];
      sb.push_back(ex[c]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({q, busy, done, err} !== {e.q, e.busy, e.done, e.err}) begin
        errors++;
        $display("[TB] FAIL selfcorr[%0d] state: got q=%b busy=%b done=%b err=%b, expected q=%b busy=%b done=%b err=%b",
                 c, q, busy, done, err, e.q, e.busy, e.done, e.err);
      end
      checks++;
      if (phase_idx !== exp_idx(e.q) || phase !== (8'd1 << exp_idx(e.q))) begin
        errors++;
        $display("[TB] FAIL selfcorr[%0d] decode: got idx=%0d phase=%b, expected idx=%0d phase=%b",
                 c, phase_idx, phase, exp_idx(e.q), 8'd1 << exp_idx(e.q));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    load = 1'b1; load_val = 4'b0000;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b1; dir = 1'b0; steps = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, busy} !== {4'b0011, 1'b1}) begin
      errors++;
      $display("[TB] FAIL midrun pre-reset: got q=%b busy=%b, expected q=0011 busy=1", q, busy);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q, phase, phase_idx, busy, done, err} !== {4'b0000, 8'b00000001, 3'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL midrun reset: got q=%b phase=%b idx=%0d busy=%b done=%b err=%b, expected 0000/00000001/0/0/0/0",
               q, phase, phase_idx, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({q, busy, done} !== {4'b0000, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL midrun after[%0d]: got q=%b busy=%b done=%b, expected q=0000 busy=0 done=0",
                 c, q, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_zero_steps();
    test_abort();
    test_self_correct();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no end of run, expected finish before 100000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
